// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: default widths,
// the instruction size used for PC stepping, and the prefetch entry layout.
package instruction_prefetch_unit_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int INSTR_BYTES  = 4;

   localparam logic [XLEN_DEFAULT-1:0] RESET_VECTOR_DEFAULT = '0;

   // One prefetched instruction tagged with the address it was fetched from.
   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_prefetch_unit_fetch_fifo.sv
// Synchronous prefetch FIFO. DEPTH must be a power of two so the read and
// write pointers wrap without extra compare logic. A flush empties the queue
// in one cycle and overrides any push or pop presented in the same cycle.
module instruction_prefetch_unit_fetch_fifo
   import instruction_prefetch_unit_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter int  CNT_W   = $clog2(DEPTH) + 1,
   parameter type entry_t = fetch_entry_t
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   output entry_t           head,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t           storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && !empty && !flush;

   // Pointer and occupancy bookkeeping; flush returns the queue to empty.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Entry storage holds data only, so it is written on push and never reset.
   always_ff @(posedge clock) begin
      if (do_push) begin
         storage[wr_ptr] <= push_data;
      end
   end

   assign head  = storage[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // The issue credit upstream must make a push into a full queue impossible.
   no_push_when_full : assert property (@(posedge clock) disable iff (reset)
      !(do_push && full));

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit. Generates sequential fetch addresses on a
// valid/ready request port, tags in-order memory responses with their PC and
// queues them for decode. The sum of queued entries and outstanding requests
// never exceeds FIFO_DEPTH, so every response always has a free slot. A
// redirect flushes the queue, restarts fetch at the target and marks every
// request still in flight as stale so its response is discarded.
module instruction_prefetch_unit
   import instruction_prefetch_unit_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
   parameter int              FIFO_DEPTH   = 4,
   parameter int              CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic            clock,
   input  logic            reset,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_resp_valid,
   input  logic [XLEN-1:0] mem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_data,
   output logic [XLEN-1:0] instr_pc
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } prefetch_entry_t;

   // Clears the byte offset so fetch always restarts on an instruction boundary.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(INSTR_BYTES - 1);
   endfunction

   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  resp_pc;
   logic [XLEN-1:0]  target_aligned;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_next;
   logic [CNT_W-1:0] drop;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   credit_used;
   logic             req_fire;
   logic             resp_stale;
   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             fifo_full;
   prefetch_entry_t  push_entry;
   prefetch_entry_t  head_entry;

   assign target_aligned = align_word(redirect_target);

   // Queue slots already used plus slots promised to in-flight requests.
   assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

   assign mem_req_valid = !reset && !redirect_valid && !fifo_full
                          && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign mem_req_addr  = fetch_pc;
   assign req_fire      = mem_req_valid && mem_req_ready;

   // Every response retires one outstanding request, kept or discarded.
   assign resp_stale       = mem_resp_valid && (drop != '0);
   assign push             = mem_resp_valid && (drop == '0) && !redirect_valid;
   assign pop              = instr_valid && instr_ready && !redirect_valid;
   assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(mem_resp_valid);

   assign push_entry.pc    = resp_pc;
   assign push_entry.instr = mem_resp_data;

   // Fetch side: address of the next request and count of requests in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc    <= RESET_VECTOR;
         outstanding <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            fetch_pc <= target_aligned;
         end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
         end
      end
   end

   // Response side: PC tag for the next kept word and count of stale words.
   always_ff @(posedge clock) begin
      if (reset) begin
         resp_pc <= RESET_VECTOR;
         drop    <= '0;
      end else if (redirect_valid) begin
         resp_pc <= target_aligned;
         drop    <= outstanding_next;
      end else begin
         if (push) begin
            resp_pc <= resp_pc + XLEN'(INSTR_BYTES);
         end
         if (resp_stale) begin
            drop <= drop - CNT_W'(1);
         end
      end
   end

   instruction_prefetch_unit_fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .CNT_W   (CNT_W),
      .entry_t (prefetch_entry_t)
   ) u_fetch_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_entry),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign instr_valid = !fifo_empty;
   assign instr_data  = head_entry.instr;
   assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed bench for instruction_prefetch_unit with an in-order memory model
// of configurable latency. Instruction words are a fixed function of address.
module tb_instruction_prefetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;

   int checks   = 0;
   int failures = 0;

   instruction_prefetch_unit #(
      .XLEN         (32),
      .RESET_VECTOR (32'h100),
      .FIFO_DEPTH   (4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_req_addr    (mem_req_addr),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_data   (mem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr_data      (instr_data),
      .instr_pc        (instr_pc)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // Memory model: accepted request at edge e is answered in the cycle after edge e+lat-1.
   logic [31:0] q_addr[$];
   int          q_due[$];
   int          cyc = 0;
   int          fire_cnt = 0;
   int          lat = 1;

   always @(posedge clock) begin
      cyc = cyc + 1;
      if (reset) begin
         q_addr.delete();
         q_due.delete();
         mem_resp_valid <= 1'b0;
      end else begin
         if (mem_req_valid && mem_req_ready) begin
            q_addr.push_back(mem_req_addr);
            q_due.push_back(cyc + lat - 1);
            fire_cnt = fire_cnt + 1;
         end
         if (q_due.size() > 0 && q_due[0] <= cyc) begin
            mem_resp_valid <= 1'b1;
            mem_resp_data  <= mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end else begin
            mem_resp_valid <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      repeat (3) tick();
      #1;
      checks++;
      if (mem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_req_valid: got %b want 0", mem_req_valid);
      end
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_instr_valid: got %b want 0", instr_valid);
      end
      checks++;
      if (mem_req_addr !== 32'h100) begin
         failures++;
         $display("FAIL reset_req_addr: got %h want 00000100", mem_req_addr);
      end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      lat = 1; instr_ready = 1'b1; mem_req_ready = 1'b1;
      do_reset();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
         failures++;
         $display("FAIL first_req: got v=%b a=%h want v=1 a=00000100", mem_req_valid, mem_req_addr);
      end
   endtask

   task automatic test_stream();
      lat = 1; instr_ready = 1'b1; mem_req_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            tick();
            #1;
         end
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 + 32'(4 * i)) begin
            failures++;
            $display("FAIL stream_req[%0d]: got v=%b a=%h want v=1 a=%h", i, mem_req_valid,
                     mem_req_addr, 32'h100 + 32'(4 * i));
         end
         if (i >= 2) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h100 + 32'(4 * (i - 2))
                || instr_data !== mem_word(32'h100 + 32'(4 * (i - 2)))) begin
               failures++;
               $display("FAIL stream_instr[%0d]: got v=%b pc=%h d=%h want pc=%h", i, instr_valid,
                        instr_pc, instr_data, 32'h100 + 32'(4 * (i - 2)));
            end
         end
      end
   endtask

   task automatic test_fill_stall();
      int n0;
      lat = 3; instr_ready = 1'b0; mem_req_ready = 1'b1;
      do_reset();
      redirect_valid = 1'b1; redirect_target = 32'h0;
      #1;
      checks++;
      if (mem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL fill_redirect_noreq: got %b want 0", mem_req_valid);
      end
      n0 = fire_cnt;
      tick();
      redirect_valid = 1'b0;
      repeat (10) tick();
      #1;
      checks++;
      if (fire_cnt - n0 != 4) begin
         failures++;
         $display("FAIL fill_req_count: got %0d want 4", fire_cnt - n0);
      end
      checks++;
      if (mem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL fill_req_stopped: got %b want 0", mem_req_valid);
      end
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr_data !== mem_word(32'(4 * i))) begin
            failures++;
            $display("FAIL fill_entry[%0d]: got v=%b pc=%h d=%h want pc=%h", i, instr_valid,
                     instr_pc, instr_data, 32'(4 * i));
         end
         tick();
         #1;
      end
   endtask

   task automatic test_redirect_outstanding();
      int n0;
      bit found;
      lat = 3; instr_ready = 1'b1; mem_req_ready = 1'b1;
      do_reset();
      n0 = fire_cnt;
      tick();
      tick();
      #1;
      checks++;
      if (fire_cnt - n0 != 2 || mem_resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir_setup: got fires=%0d resp=%b want 2 and 0", fire_cnt - n0, mem_resp_valid);
      end
      redirect_valid = 1'b1; redirect_target = 32'h2003;
      #1;
      checks++;
      if (mem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir_noreq: got %b want 0", mem_req_valid);
      end
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir_flush: got %b want 0", instr_valid);
      end
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000) begin
         failures++;
         $display("FAIL redir_addr: got v=%b a=%h want v=1 a=00002000", mem_req_valid, mem_req_addr);
      end
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (instr_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
         #1;
      end
      checks++;
      if (!found || instr_pc !== 32'h2000 || instr_data !== mem_word(32'h2000)) begin
         failures++;
         $display("FAIL redir_first: got found=%b pc=%h d=%h want pc=00002000", found, instr_pc, instr_data);
      end
      tick();
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h2004) begin
         failures++;
         $display("FAIL redir_second: got v=%b pc=%h want pc=00002004", instr_valid, instr_pc);
      end
   endtask

   task automatic test_redirect_collision();
      bit found;
      lat = 2; instr_ready = 1'b1; mem_req_ready = 1'b1;
      do_reset();
      repeat (4) tick();
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h104 || mem_resp_valid !== 1'b1
          || mem_resp_data !== mem_word(32'h108)) begin
         failures++;
         $display("FAIL coll_setup: got v=%b pc=%h resp=%b want v=1 pc=00000104 resp=1",
                  instr_valid, instr_pc, mem_resp_valid);
      end
      redirect_valid = 1'b1; redirect_target = 32'h3000;
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL coll_flush: got %b want 0", instr_valid);
      end
      checks++;
      if (dut.drop !== 3'd1 || dut.outstanding !== 3'd1) begin
         failures++;
         $display("FAIL coll_drop: got drop=%0d out=%0d want 1 and 1", dut.drop, dut.outstanding);
      end
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (instr_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
         #1;
      end
      checks++;
      if (!found || instr_pc !== 32'h3000 || instr_data !== mem_word(32'h3000)) begin
         failures++;
         $display("FAIL coll_first: got found=%b pc=%h want pc=00003000", found, instr_pc);
      end
   endtask

   task automatic test_req_stall();
      lat = 1; instr_ready = 1'b1; mem_req_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got v=%b a=%h want v=1 a=00000100", i, mem_req_valid, mem_req_addr);
         end
         tick();
         #1;
      end
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_nofifo: got %b want 0", instr_valid);
      end
      mem_req_ready = 1'b1;
      tick();
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h104) begin
         failures++;
         $display("FAIL stall_resume: got v=%b a=%h want v=1 a=00000104", mem_req_valid, mem_req_addr);
      end
      tick();
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
         failures++;
         $display("FAIL stall_instr: got v=%b pc=%h want v=1 pc=00000100", instr_valid, instr_pc);
      end
   endtask

   task automatic test_wrap_and_reset();
      lat = 1; instr_ready = 1'b1; mem_req_ready = 1'b1;
      do_reset();
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (mem_req_addr !== 32'hFFFF_FFF8) begin
         failures++;
         $display("FAIL wrap_req0: got %h want fffffff8", mem_req_addr);
      end
      tick();
      #1;
      checks++;
      if (mem_req_addr !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_req1: got %h want fffffffc", mem_req_addr);
      end
      tick();
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
         failures++;
         $display("FAIL wrap_req2: got v=%b a=%h want v=1 a=00000000", mem_req_valid, mem_req_addr);
      end
      tick();
      tick();
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== mem_word(32'h0)) begin
         failures++;
         $display("FAIL wrap_instr: got v=%b pc=%h d=%h want pc=00000000", instr_valid, instr_pc, instr_data);
      end
      reset = 1'b1;
      tick();
      #1;
      checks++;
      if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0 || mem_req_addr !== 32'h100) begin
         failures++;
         $display("FAIL midreset: got rv=%b iv=%b a=%h want 0 0 00000100", mem_req_valid, instr_valid, mem_req_addr);
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fill_stall();
      test_redirect_outstanding();
      test_redirect_collision();
      test_req_stall();
      test_wrap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
